alu_secuencial_param: RTL and testbench

- Parametrised, registered successor of the team's 4-bit combinational ALU; same 3-bit opcode map, generalised to WIDTH-bit operands.
- Adds a valid/ready handshake on input and output, a multi-cycle shift-add multiplier, variable shift amounts and status flags.
- Sits between the register file / operand latches and the result bus of the datapath; accepts one operation at a time.

---
 rtl/alu_secuencial_param.sv | 208 ++++++++++++++++++++
 tb/tb_alu_secuencial_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_secuencial_param.sv
// alu_secuencial_param: registered WIDTH-bit ALU with valid/ready handshakes on
// both sides, a shift-add multiplier, variable shifts and zero/carry flags.
// Optional build macro: ALU_SEQ_SIGNED_EN selects signed compare, arithmetic
// right shift and signed multiply. The port list is the same in both builds.
module alu_secuencial_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         sel,
    input  logic               dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] c,
    output logic               zero,
    output logic               carry
);

    localparam int SHW = $clog2(WIDTH);
    localparam int W2  = 2 * WIDTH;
    localparam int CW  = $clog2(WIDTH + 1);

`ifdef ALU_SEQ_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_SHF = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [W2-1:0]   c_reg, c_next;
    logic            zero_reg, zero_next;
    logic            carry_reg, carry_next;
    logic [W2-1:0]   acc_reg, acc_next;
    logic [W2-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    // single-cycle datapath results, evaluated straight off the input operands
    logic [W2-1:0]   alu_c;
    logic            alu_carry;
    logic [WIDTH:0]  sum_ext;
    logic [W2-1:0]   shl;
    logic [W2-1:0]   shr;
    logic [W2-1:0]   shr_src;
    logic [SHW-1:0]  amt;
    logic            gt;
    logic [W2-1:0]   a_ext;
    logic [W2-1:0]   pp;
    logic [W2-1:0]   mac;

    assign amt       = b[SHW-1:0];
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign c         = c_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;

    // multiplicand widened to the product width (sign-extended in the signed build)
    always_comb begin
        if (SIGNED_MODE) a_ext = {{WIDTH{a[WIDTH-1]}}, a};
        else             a_ext = {{WIDTH{1'b0}}, a};
    end

    // combinational result and carry for every opcode except multiply
    always_comb begin
        alu_c     = '0;
        alu_carry = 1'b0;
        sum_ext   = '0;
        shl       = '0;
        shr       = '0;
        gt        = 1'b0;
        // operand placed in the upper half so bits falling off the right land
        // in the lower half; the top bit of the lower half is the last one out
        shr_src   = {a, {WIDTH{1'b0}}};
        case (sel)
            OP_ADD: begin
                sum_ext          = {1'b0, a} + {1'b0, b};
                alu_c[WIDTH:0]   = sum_ext;
                alu_carry        = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_c[WIDTH-1:0] = a - b;
                alu_carry        = (a < b);
            end
            OP_AND: alu_c[WIDTH-1:0] = a & b;
            OP_OR:  alu_c[WIDTH-1:0] = a | b;
            OP_XOR: alu_c[WIDTH-1:0] = a ^ b;
            OP_CMP: begin
                if (SIGNED_MODE) gt = ($signed(a) > $signed(b));
                else             gt = (a > b);
                if (a == b)      alu_c[1:0] = 2'd1;
                else if (gt)     alu_c[1:0] = 2'd2;
                else             alu_c[1:0] = 2'd0;
            end
            OP_SHF: begin
                if (!dir) begin
                    // bit WIDTH of the widened shift is the last bit pushed out
                    shl              = {{WIDTH{1'b0}}, a} << amt;
                    alu_c[WIDTH-1:0] = shl[WIDTH-1:0];
                    alu_carry        = shl[WIDTH];
                end else begin
                    if (SIGNED_MODE) shr = $signed(shr_src) >>> amt;
                    else             shr = shr_src >> amt;
                    alu_c[WIDTH-1:0] = shr[W2-1:WIDTH];
                    alu_carry        = shr[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    // state register and all datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            c_reg      <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            c_reg      <= c_next;
            zero_reg   <= zero_next;
            carry_reg  <= carry_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    // next-state and datapath update; the accept edge already folds in the
    // partial product of b[0], so the product is ready WIDTH edges after accept
    always_comb begin
        state_next  = state_reg;
        c_next      = c_reg;
        zero_next   = zero_reg;
        carry_next  = carry_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;

        pp = mplier_reg[0] ? mcand_reg : '0;
        // in the signed build the multiplier MSB has negative weight, so its
        // partial product (the final iteration) is subtracted
        if (SIGNED_MODE && (cnt_reg == CW'(1))) mac = acc_reg - pp;
        else                                    mac = acc_reg + pp;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (sel == OP_MUL) begin
                        acc_next    = b[0] ? a_ext : '0;
                        mcand_next  = a_ext << 1;
                        mplier_next = b >> 1;
                        cnt_next    = CW'(WIDTH - 1);
                        state_next  = MUL;
                    end else begin
                        c_next      = alu_c;
                        carry_next  = alu_carry;
                        zero_next   = (alu_c == '0);
                        state_next  = DONE;
                    end
                end
            end
            MUL: begin
                acc_next    = mac;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    c_next     = mac;
                    carry_next = 1'b0;
                    zero_next  = (mac == '0);
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_secuencial_param.sv
// tb_alu_secuencial_param: directed and random-vector bench for the sequential
// ALU at WIDTH=8; expected results come from hand values or a behavioural model.
module tb_alu_secuencial_param;

`ifdef ALU_SEQ_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [2:0]  sel = '0;
    logic        dir = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] c;
    logic        zero;
    logic        carry;

    int n_cmp = 0;
    int n_err = 0;

    alu_secuencial_param #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .dir(dir), .out_valid(out_valid),
        .out_ready(out_ready), .c(c), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // present one operation, hold in_valid for its accept edge, then count
    // edges until out_valid (lat = 1 means valid right after the accept edge)
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts,
                        input logic td, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a = ta; b = tb; sel = ts; dir = td; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom); dir = 1'($urandom);
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("op a=%02h b=%02h sel=%0d dir=%0d -> c=%04h carry=%0d zero=%0d lat=%0d",
                 ta, tb, ts, td, c, carry, zero, lat);
    endtask

    // check the presented result, then consume it and confirm return to IDLE
    task automatic take(input string tag, input logic [15:0] ec, input logic ecar, input logic ezr);
        check({tag, ".c"}, 32'(c), 32'(ec));
        check({tag, ".carry"}, 32'(carry), 32'(ecar));
        check({tag, ".zero"}, 32'(zero), 32'(ezr));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    // behavioural reference for the random section
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] ms,
                         input logic md, output logic [15:0] ec, output logic ecar);
        logic [7:0]         v;
        logic signed [15:0] p;
        ec = '0;
        ecar = 1'b0;
        case (ms)
            3'd0: begin ec = 16'(ma) + 16'(mb); ecar = ec[8]; end
            3'd1: begin ec[7:0] = ma - mb; ecar = (ma < mb); end
            3'd2: ec[7:0] = ma & mb;
            3'd3: ec[7:0] = ma | mb;
            3'd4: ec[7:0] = ma ^ mb;
            3'd5: begin
                if (ma == mb) ec = 16'd1;
                else if (SGN ? ($signed(ma) > $signed(mb)) : (ma > mb)) ec = 16'd2;
                else ec = 16'd0;
            end
            3'd6: begin
                v = ma;
                for (int i = 0; i < int'(mb[2:0]); i++) begin
                    if (!md) begin ecar = v[7]; v = {v[6:0], 1'b0}; end
                    else begin ecar = v[0]; v = {SGN ? v[7] : 1'b0, v[7:1]}; end
                end
                ec[7:0] = v;
            end
            default: begin
                if (SGN) begin
                    p = $signed(ma) * $signed(mb);
                    ec = p;
                end else begin
                    ec = 16'(ma) * 16'(mb);
                end
            end
        endcase
    endtask

    initial begin
        int          lat;
        logic [15:0] ec;
        logic        ecar;
        logic        seen;
        logic [7:0]  ra, rb;
        logic [2:0]  rs;
        logic        rd;

        // reset state
        #12;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.c", 32'(c), 32'd0);
        check("rst.flags", {30'd0, zero, carry}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset during a multiply discards it
        @(negedge clk);
        a = 8'd200; b = 8'd200; sel = 3'b111; dir = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mulrst.in_ready", 32'(in_ready), 32'd1);
        check("mulrst.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mulrst.no_output", 32'(seen), 32'd0);
        check("mulrst.c", 32'(c), 32'd0);
        check("mulrst.ready", 32'(in_ready), 32'd1);
        $display("reset during multiply: out_valid_seen=%0d c=%04h", seen, c);

        // add with carry, sub with borrow
        send(8'd200, 8'd100, 3'b000, 1'b0, lat);
        check("add.lat", 32'(lat), 32'd1);
        take("add", 16'h012C, 1'b1, 1'b0);
        send(8'd5, 8'd9, 3'b001, 1'b0, lat);
        check("sub.lat", 32'(lat), 32'd1);
        take("sub", 16'h00FC, 1'b1, 1'b0);

        // multiply latency and results
        send(8'd255, 8'd255, 3'b111, 1'b0, lat);
        check("mul255.lat", 32'(lat), 32'd8);
        take("mul255", SGN ? 16'h0001 : 16'hFE01, 1'b0, 1'b0);
        send(8'd0, 8'd37, 3'b111, 1'b0, lat);
        check("mul0.lat", 32'(lat), 32'd8);
        take("mul0", 16'h0000, 1'b0, 1'b1);

        // backpressure: result holds, in_valid pulses ignored
        send(8'd10, 8'd20, 3'b000, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp.c", 32'(c), 32'd30);
            check("bp.hs", {30'd0, out_valid, in_ready}, 32'b10);
            a = 8'($urandom); b = 8'($urandom); sel = 3'b001; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        take("bp", 16'd30, 1'b0, 1'b0);

        // shifts and compare
        send(8'h81, 8'd1, 3'b110, 1'b0, lat);
        take("shl1", 16'h0002, 1'b1, 1'b0);
        send(8'h81, 8'd7, 3'b110, 1'b1, lat);
        take("shr7", SGN ? 16'h00FF : 16'h0001, 1'b0, 1'b0);
        send(8'h5A, 8'd0, 3'b110, 1'b0, lat);
        take("shl0", 16'h005A, 1'b0, 1'b0);
        send(8'h80, 8'h01, 3'b101, 1'b0, lat);
        take("cmp", SGN ? 16'd0 : 16'd2, 1'b0, SGN);
        send(8'h33, 8'h33, 3'b101, 1'b0, lat);
        take("cmpeq", 16'd1, 1'b0, 1'b0);
        send(8'hF0, 8'h3C, 3'b100, 1'b0, lat);
        take("xor", 16'h00CC, 1'b0, 1'b0);

        // random back-to-back operations against the model
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 3'($urandom_range(0, 7)); rd = 1'($urandom);
            model(ra, rb, rs, rd, ec, ecar);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(ra, rb, rs, rd, lat);
            check($sformatf("rnd%0d.lat", i), 32'(lat), (rs == 3'b111) ? 32'd8 : 32'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take($sformatf("rnd%0d", i), ec, ecar, (ec == 16'd0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
